// File: rtl/signed_acc_16.sv
// Signed Q8.8 vector accumulator: sums VEC_LEN beats in 24 bits and
// emits a saturated 16-bit result over a valid/ready handshake.
module signed_acc_16 #(
  parameter int VEC_LEN = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] prod_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic signed [15:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sat
);

  localparam int CW = $clog2(VEC_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(VEC_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic signed [23:0] acc, acc_nxt;
  logic signed [23:0] ext, sum;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic signed [15:0] data_nxt, clip_data;
  logic               valid_nxt, sat_nxt;
  logic               accept, hi, lo;

  assign in_ready = (state != DONE);
  assign accept   = in_valid & in_ready;

  assign ext = {{8{prod_in[15]}}, prod_in};
  assign sum = acc + ext;

  // Clip from the registered final sum, keeping it off the adder path.
  assign hi = (acc > 24'sd32767);
  assign lo = (acc < -24'sd32768);
  assign clip_data = hi ? 16'sh7FFF
                   : lo ? 16'sh8000
                   : acc[15:0];

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    data_nxt  = out_data;
    valid_nxt = out_valid;
    sat_nxt   = out_sat;
    unique case (state)
      IDLE: begin
        if (accept) begin
          acc_nxt   = ext;
          cnt_nxt   = CW'(1);
          state_nxt = ACC;
        end
      end
      ACC: begin
        if (accept) begin
          acc_nxt = sum;
          cnt_nxt = cnt + CW'(1);
          if (cnt == LAST) state_nxt = DONE;
        end
      end
      DONE: begin
        if (!out_valid) begin
          valid_nxt = 1'b1;
          data_nxt  = clip_data;
          sat_nxt   = hi | lo;
        end else if (out_ready) begin
          valid_nxt = 1'b0;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sat   <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      out_data  <= data_nxt;
      out_valid <= valid_nxt;
      out_sat   <= sat_nxt;
    end
  end

endmodule
